// File: rtl/lrpt_pkg.sv
// lrpt_pkg -- shared types for the LRPT unique-word sync controller.
//   sync_state_t : controller FSM states (IDLE, FEED, WAIT_RES, EVAL).
//   rotation_t   : constellation rotation reported by the correlator,
//                  0 = 0 deg, 1 = 90 deg, 2 = 180 deg, 3 = 270 deg.
package lrpt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FEED     = 2'd1,
        ST_WAIT_RES = 2'd2,
        ST_EVAL     = 2'd3
    } sync_state_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rotation_t;

endpackage

// File: rtl/uw_sync_ctrl_if.sv
// uw_sync_ctrl_if -- bundle of every non-clock/reset signal of uw_sync_ctrl.
//   Upstream bits : enable, bit_data, bit_valid, bit_ready
//   Datapath feed : corr_ready, corr_bit, corr_valid, corr_rst
//   Datapath res  : res_valid, res_offset, res_weight, res_rotation
//   Lock status   : locked, lock_offset, lock_rotation, lock_update,
//                   miss_count, timeout_err
// master : the environment (upstream source + correlator datapath + monitor)
// slave  : the controller side
interface uw_sync_ctrl_if #(
    parameter int BITS_PER_FRAME = 80,
    parameter int MAX_CORR_VAL   = 257,
    parameter int UNLOCK_MISSES  = 3
);
    logic                               enable;
    logic                               bit_data;
    logic                               bit_valid;
    logic                               bit_ready;
    logic                               corr_ready;
    logic                               corr_bit;
    logic                               corr_valid;
    logic                               corr_rst;
    logic                               res_valid;
    logic [$clog2(BITS_PER_FRAME)-1:0]  res_offset;
    logic [$clog2(MAX_CORR_VAL)-1:0]    res_weight;
    logic [1:0]                         res_rotation;
    logic                               locked;
    logic [$clog2(BITS_PER_FRAME)-1:0]  lock_offset;
    logic [1:0]                         lock_rotation;
    logic                               lock_update;
    logic [$clog2(UNLOCK_MISSES+1)-1:0] miss_count;
    logic                               timeout_err;

    modport master (
        output enable, bit_data, bit_valid, corr_ready,
               res_valid, res_offset, res_weight, res_rotation,
        input  bit_ready, corr_bit, corr_valid, corr_rst,
               locked, lock_offset, lock_rotation, lock_update,
               miss_count, timeout_err
    );

    modport slave (
        input  enable, bit_data, bit_valid, corr_ready,
               res_valid, res_offset, res_weight, res_rotation,
        output bit_ready, corr_bit, corr_valid, corr_rst,
               locked, lock_offset, lock_rotation, lock_update,
               miss_count, timeout_err
    );

endinterface

// File: rtl/uw_sync_ctrl.sv
// uw_sync_ctrl -- acquisition controller for the unique-word correlator.
// Streams one window (BITS_PER_FRAME*NUM_FRAMES hard bits) into the
// correlator datapath, waits for its best-match result and maintains the
// lock state with miss hysteresis.
// Ports:
//   clk, rst_in_n                  : clock, async active-low reset
//   enable_in                      : permits starting a new window
//   bit_in/bit_valid_in/bit_ready_out : upstream bit handshake
//   corr_ready_in                  : datapath ready to receive a window
//   corr_bit_out/corr_valid_out    : registered bit stream to datapath
//   corr_rst_out                   : one-cycle datapath reset (abort/timeout)
//   corr_result_valid_in/_offset_in/_weight_in/_rotation_in : datapath result
//   locked_out, lock_offset_out, lock_rotation_out : lock status/values
//   lock_update_out                : pulse on every lock-value refresh
//   miss_count_out                 : consecutive weak windows while locked
//   timeout_err_out                : sticky result-timeout flag
module uw_sync_ctrl
    import lrpt_pkg::*;
#(
    parameter int BITS_PER_FRAME = 80,
    parameter int NUM_FRAMES     = 32,
    parameter int MAX_CORR_VAL   = 257,
    parameter int LOCK_THRESH    = 224,
    parameter int UNLOCK_MISSES  = 3,
    parameter int RES_TIMEOUT    = 64
) (
    input  logic                               clk,
    input  logic                               rst_in_n,
    input  logic                               enable_in,
    input  logic                               bit_in,
    input  logic                               bit_valid_in,
    output logic                               bit_ready_out,
    input  logic                               corr_ready_in,
    output logic                               corr_bit_out,
    output logic                               corr_valid_out,
    output logic                               corr_rst_out,
    input  logic                               corr_result_valid_in,
    input  logic [$clog2(BITS_PER_FRAME)-1:0]  corr_offset_in,
    input  logic [$clog2(MAX_CORR_VAL)-1:0]    corr_weight_in,
    input  logic [1:0]                         corr_rotation_in,
    output logic                               locked_out,
    output logic [$clog2(BITS_PER_FRAME)-1:0]  lock_offset_out,
    output logic [1:0]                         lock_rotation_out,
    output logic                               lock_update_out,
    output logic [$clog2(UNLOCK_MISSES+1)-1:0] miss_count_out,
    output logic                               timeout_err_out
);

    localparam int WINDOW = BITS_PER_FRAME * NUM_FRAMES;
    localparam int CW     = $clog2(WINDOW);
    localparam int OW     = $clog2(BITS_PER_FRAME);
    localparam int WW     = $clog2(MAX_CORR_VAL);
    localparam int MW     = $clog2(UNLOCK_MISSES + 1);
    localparam int TW     = $clog2(RES_TIMEOUT + 1);

    localparam logic [CW-1:0] BIT_LAST    = CW'(WINDOW - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(RES_TIMEOUT - 1);
    localparam logic [WW-1:0] THRESH      = WW'(LOCK_THRESH);
    localparam logic [MW-1:0] MISS_LIMIT  = MW'(UNLOCK_MISSES);

    sync_state_t     state_reg;
    logic [CW-1:0]   bit_cnt_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic [OW-1:0]   cap_offset_reg;
    logic [WW-1:0]   cap_weight_reg;
    rotation_t       cap_rotation_reg;

    logic            accept;
    logic [MW-1:0]   miss_next;

    assign bit_ready_out = (state_reg == ST_FEED);
    assign accept        = bit_valid_in && bit_ready_out;
    assign miss_next     = miss_count_out + 1'b1;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg         <= ST_IDLE;
            bit_cnt_reg       <= '0;
            tmo_cnt_reg       <= '0;
            cap_offset_reg    <= '0;
            cap_weight_reg    <= '0;
            cap_rotation_reg  <= ROT_0;
            corr_bit_out      <= 1'b0;
            corr_valid_out    <= 1'b0;
            corr_rst_out      <= 1'b0;
            locked_out        <= 1'b0;
            lock_offset_out   <= '0;
            lock_rotation_out <= '0;
            lock_update_out   <= 1'b0;
            miss_count_out    <= '0;
            timeout_err_out   <= 1'b0;
        end else begin
            // Bit path to the datapath is a plain one-cycle pipeline stage.
            corr_valid_out  <= accept;
            if (accept) begin
                corr_bit_out <= bit_in;
            end
            corr_rst_out    <= 1'b0;
            lock_update_out <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (enable_in && corr_ready_in) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_FEED;
                    end
                end

                ST_FEED: begin
                    if (bit_valid_in) begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            bit_cnt_reg <= '0;
                            tmo_cnt_reg <= '0;
                            state_reg   <= ST_WAIT_RES;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (bit_cnt_reg != '0) begin
                        // A gap inside a window breaks frame alignment in the
                        // correlator, so the partial window is thrown away.
                        corr_rst_out <= 1'b1;
                        bit_cnt_reg  <= '0;
                        state_reg    <= ST_IDLE;
                    end
                end

                ST_WAIT_RES: begin
                    if (corr_result_valid_in) begin
                        cap_offset_reg   <= corr_offset_in;
                        cap_weight_reg   <= corr_weight_in;
                        cap_rotation_reg <= rotation_t'(corr_rotation_in);
                        state_reg        <= ST_EVAL;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        corr_rst_out    <= 1'b1;
                        timeout_err_out <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                ST_EVAL: begin
                    if (cap_weight_reg >= THRESH) begin
                        locked_out        <= 1'b1;
                        lock_offset_out   <= cap_offset_reg;
                        lock_rotation_out <= cap_rotation_reg;
                        miss_count_out    <= '0;
                        lock_update_out   <= 1'b1;
                    end else if (locked_out) begin
                        // Lock is only dropped after a run of weak windows;
                        // offset/rotation keep their last good values.
                        if (miss_next == MISS_LIMIT) begin
                            locked_out     <= 1'b0;
                            miss_count_out <= '0;
                        end else begin
                            miss_count_out <= miss_next;
                        end
                    end
                    state_reg <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uw_sync_ctrl.sv
// tb_uw_sync_ctrl -- self-checking bench for uw_sync_ctrl.
// A table of correlator results is applied window by window; the expected
// lock status for each result goes into a scoreboard queue when the result
// is driven and is popped and compared once the controller has evaluated it.
// Hand-written sequences cover abort, timeout, stray results and reset.
module tb_uw_sync_ctrl;
    import lrpt_pkg::*;

    localparam int BPF    = 80;
    localparam int NFR    = 32;
    localparam int WINDOW = BPF * NFR;
    localparam int TMO    = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uw_sync_ctrl_if #(.BITS_PER_FRAME(BPF), .MAX_CORR_VAL(257), .UNLOCK_MISSES(3)) bus ();

    uw_sync_ctrl #(
        .BITS_PER_FRAME(BPF), .NUM_FRAMES(NFR), .MAX_CORR_VAL(257),
        .LOCK_THRESH(224), .UNLOCK_MISSES(3), .RES_TIMEOUT(TMO)
    ) dut (
        .clk                  (clk),
        .rst_in_n             (rst_n),
        .enable_in            (bus.enable),
        .bit_in               (bus.bit_data),
        .bit_valid_in         (bus.bit_valid),
        .bit_ready_out        (bus.bit_ready),
        .corr_ready_in        (bus.corr_ready),
        .corr_bit_out         (bus.corr_bit),
        .corr_valid_out       (bus.corr_valid),
        .corr_rst_out         (bus.corr_rst),
        .corr_result_valid_in (bus.res_valid),
        .corr_offset_in       (bus.res_offset),
        .corr_weight_in       (bus.res_weight),
        .corr_rotation_in     (bus.res_rotation),
        .locked_out           (bus.locked),
        .lock_offset_out      (bus.lock_offset),
        .lock_rotation_out    (bus.lock_rotation),
        .lock_update_out      (bus.lock_update),
        .miss_count_out       (bus.miss_count),
        .timeout_err_out      (bus.timeout_err)
    );

    typedef struct {
        int weight;
        int offset;
        int rot;
        int exp_locked;
        int exp_off;
        int exp_rot;
        int exp_miss;
        int exp_upd;
    } vec_t;

    vec_t vecs [8];
    vec_t sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outputs();
        return {bus.bit_ready, bus.corr_bit, bus.corr_valid, bus.corr_rst,
                bus.locked, bus.lock_offset, bus.lock_rotation, bus.lock_update,
                bus.miss_count, bus.timeout_err};
    endfunction

    // Starts a window and feeds bits. gap: cycles with bit_valid low right
    // after entering FEED (must not abort). stop_at < 0 feeds until the
    // controller stops accepting; otherwise stops after stop_at bits.
    task automatic run_window(input string tag, input int gap, input int stop_at,
                              output int accepted);
        int  w;
        int  gerr;
        int  berr;
        logic b;
        bus.enable     = 1'b1;
        bus.corr_ready = 1'b1;
        bus.bit_valid  = 1'b0;
        w = 0;
        while (!bus.bit_ready && w < 10) begin
            tick();
            w++;
        end
        check({tag, " enter_feed"}, bus.bit_ready, 1);
        // Dropping enable mid-window must not disturb the window.
        bus.enable = 1'b0;
        gerr = 0;
        for (int i = 0; i < gap; i++) begin
            tick();
            if (!bus.bit_ready || bus.corr_rst) gerr++;
        end
        if (gap > 0) check({tag, " idle_gap_hold"}, gerr, 0);
        accepted = 0;
        berr = 0;
        while (bus.bit_ready && accepted < WINDOW + 4 && (stop_at < 0 || accepted < stop_at)) begin
            b = 1'($urandom_range(0, 1));
            bus.bit_data  = b;
            bus.bit_valid = 1'b1;
            tick();
            accepted++;
            if (!(bus.corr_valid === 1'b1 && bus.corr_bit === b)) berr++;
        end
        bus.bit_valid = 1'b0;
        check({tag, " bit_path"}, berr, 0);
        if (stop_at < 0) check({tag, " window_len"}, accepted, WINDOW);
    endtask

    task automatic deliver(input string tag, input vec_t v);
        vec_t e;
        bus.res_valid    = 1'b1;
        bus.res_weight   = 9'(v.weight);
        bus.res_offset   = 7'(v.offset);
        bus.res_rotation = 2'(v.rot);
        sb_q.push_back(v);
        tick();
        bus.res_valid = 1'b0;
        tick();
        e = sb_q.pop_front();
        check({tag, " locked"},      bus.locked,        e.exp_locked);
        check({tag, " lock_offset"}, bus.lock_offset,   e.exp_off);
        check({tag, " lock_rot"},    bus.lock_rotation, e.exp_rot);
        check({tag, " miss_count"},  bus.miss_count,    e.exp_miss);
        check({tag, " update"},      bus.lock_update,   e.exp_upd);
        tick();
        check({tag, " update_single"}, bus.lock_update, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   cnt;
        int   err;
        vec_t v;

        //          weight off rot  L  off rot miss upd
        vecs[0] = '{240, 17, 2,    1, 17, 2,  0,   1};
        vecs[1] = '{200,  5, 1,    1, 17, 2,  1,   0};
        vecs[2] = '{200,  6, 0,    1, 17, 2,  2,   0};
        vecs[3] = '{200,  7, 3,    0, 17, 2,  0,   0};
        vecs[4] = '{223,  3, 3,    0, 17, 2,  0,   0};
        vecs[5] = '{224, 40, 1,    1, 40, 1,  0,   1};
        vecs[6] = '{100,  2, 2,    1, 40, 1,  1,   0};
        vecs[7] = '{256, 79, 3,    1, 79, 3,  0,   1};

        bus.enable       = 1'b0;
        bus.bit_data     = 1'b0;
        bus.bit_valid    = 1'b0;
        bus.corr_ready   = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_offset   = '0;
        bus.res_weight   = '0;
        bus.res_rotation = '0;

        repeat (3) tick();
        check("reset outputs", all_outputs(), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post-reset idle", bus.bit_ready, 0);

        for (int i = 0; i < 8; i++) begin
            run_window($sformatf("vec%0d", i), (i == 0) ? 3 : 0, -1, n);
            deliver($sformatf("vec%0d", i), vecs[i]);
        end

        // Gap after 100 bits aborts the window without touching lock.
        run_window("abort", 0, 100, n);
        tick();
        check("abort corr_rst", bus.corr_rst, 1);
        check("abort idle", bus.bit_ready, 0);
        check("abort locked", bus.locked, 1);
        check("abort offset", bus.lock_offset, 79);
        tick();
        check("abort rst_single", bus.corr_rst, 0);

        // No result: reset pulse after RES_TIMEOUT cycles, sticky error flag.
        run_window("tmo", 0, -1, n);
        cnt = 0;
        while (!bus.corr_rst && cnt < 200) begin
            tick();
            cnt++;
        end
        check("tmo latency", cnt, TMO);
        check("tmo err set", bus.timeout_err, 1);
        tick();
        check("tmo rst_single", bus.corr_rst, 0);
        check("tmo err held", bus.timeout_err, 1);
        run_window("post_tmo", 0, -1, n);
        v = '{230, 9, 0, 1, 9, 0, 0, 1};
        deliver("post_tmo", v);
        check("tmo err sticky", bus.timeout_err, 1);

        // Result strobe while IDLE is ignored.
        bus.res_valid  = 1'b1;
        bus.res_weight = 9'd100;
        bus.res_offset = 7'd1;
        repeat (3) tick();
        bus.res_valid = 1'b0;
        check("stray miss", bus.miss_count, 0);
        check("stray locked", bus.locked, 1);
        check("stray offset", bus.lock_offset, 9);

        // Reset in the middle of FEED.
        run_window("rst", 0, 50, n);
        rst_n = 1'b0;
        #1;
        check("midfeed reset outputs", all_outputs(), 0);
        @(negedge clk) rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.corr_rst !== 1'b0) err++;
        end
        check("no rst pulse on release", err, 0);
        run_window("after_rst", 0, -1, n);
        v = '{250, 33, 3, 1, 33, 3, 0, 1};
        deliver("after_rst", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
